// File: rtl/alu_mem_ctrl_core.sv
// Execute-and-memory slice: opcode control decode, 32-bit ALU and a 128x32 data memory.
// Optional macro ALU_EXT_OPS_EN enables SLT (0111) and NOR (1100); otherwise those codes yield 0.
module alu_mem_ctrl_core (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  Opcode,
    input  logic [3:0]  ALUCtrl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [6:0]  MemAddress,
    input  logic [31:0] MemWriteData,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic [1:0]  ALUOp,
    output logic [31:0] ALUOut,
    output logic        Zero,
    output logic [31:0] MemReadData
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [31:0] mem_q [128];

    always_comb begin
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Branch   = 1'b0;
        ALUOp    = 2'b00;
        case (Opcode)
            OP_RTYPE: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                ALUOp    = 2'b10;
            end
            OP_LW: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
                MemtoReg = 1'b1;
                MemRead  = 1'b1;
            end
            OP_SW: begin
                ALUSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            OP_BEQ: begin
                Branch   = 1'b1;
                ALUOp    = 2'b01;
            end
            OP_ADDI: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
            end
            default: ;
        endcase
    end

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    assign a_s = A;
    assign b_s = B;

    always_comb begin
        ALUOut = 32'd0;
        case (ALUCtrl)
            4'b0000: ALUOut = A & B;
            4'b0001: ALUOut = A | B;
            4'b0010: ALUOut = A + B;
            4'b0110: ALUOut = A - B;
`ifdef ALU_EXT_OPS_EN
            4'b0111: ALUOut = {31'd0, (a_s < b_s)};
            4'b1100: ALUOut = ~(A | B);
`endif
            default: ALUOut = 32'd0;
        endcase
    end

    assign Zero = (ALUOut == 32'd0);

    // Decoded MemRead/MemWrite gate the array directly; a store cycle never drives the read port.
    assign MemReadData = (MemRead && !MemWrite) ? mem_q[MemAddress] : 32'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (MemWrite) begin
            mem_q[MemAddress] <= MemWriteData;
        end
    end

endmodule

// File: tb/tb_alu_mem_ctrl_core.sv
// Scoreboard bench for alu_mem_ctrl_core: reference model pushes expectations, checked mid-cycle.
module tb_alu_mem_ctrl_core;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  Opcode;
    logic [3:0]  ALUCtrl;
    logic [31:0] A;
    logic [31:0] B;
    logic [6:0]  MemAddress;
    logic [31:0] MemWriteData;
    logic        RegDst, RegWrite, ALUSrc, MemtoReg, MemRead, MemWrite, Branch;
    logic [1:0]  ALUOp;
    logic [31:0] ALUOut;
    logic        Zero;
    logic [31:0] MemReadData;

    always #5 clock = ~clock;

    alu_mem_ctrl_core dut (
        .clock        (clock),
        .reset        (reset),
        .Opcode       (Opcode),
        .ALUCtrl      (ALUCtrl),
        .A            (A),
        .B            (B),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .RegDst       (RegDst),
        .RegWrite     (RegWrite),
        .ALUSrc       (ALUSrc),
        .MemtoReg     (MemtoReg),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .Branch       (Branch),
        .ALUOp        (ALUOp),
        .ALUOut       (ALUOut),
        .Zero         (Zero),
        .MemReadData  (MemReadData)
    );

    typedef struct {
        logic [8:0]  ctrl;
        logic [31:0] alu;
        logic        zero;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl_mem [128];
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h want=0x%08h", tag, obs, exp);
        end
    endtask

    // {RegDst,RegWrite,ALUSrc,MemtoReg,MemRead,MemWrite,Branch,ALUOp}
    function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'b000000: return 9'b1_1_0_0_0_0_0_10;
            6'b100011: return 9'b0_1_1_1_1_0_0_00;
            6'b101011: return 9'b0_0_1_0_0_1_0_00;
            6'b000100: return 9'b0_0_0_0_0_0_1_01;
            6'b001000: return 9'b0_1_1_0_0_0_0_00;
            default:   return 9'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic lt;
        lt = (a[31] != b[31]) ? a[31] : (a < b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a + ~b + 32'd1;
`ifdef ALU_EXT_OPS_EN
            4'b0111: return lt ? 32'd1 : 32'd0;
            4'b1100: return ~a & ~b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic step(input logic rst, input logic [5:0] op, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [6:0] addr, input logic [31:0] wd, input string tag);
        exp_t e;
        exp_t got;
        reset = rst; Opcode = op; ALUCtrl = c; A = a; B = b;
        MemAddress = addr; MemWriteData = wd;
        e.ctrl = ref_ctrl(op);
        e.alu  = ref_alu(c, a, b);
        e.zero = (e.alu == 32'd0);
        e.rd   = (op == 6'b100011) ? mdl_mem[addr] : 32'd0;
        sb.push_back(e);
        #2;
        got = sb.pop_front();
        check({tag, ".ctrl"}, {23'd0, RegDst, RegWrite, ALUSrc, MemtoReg, MemRead, MemWrite, Branch, ALUOp},
              {23'd0, got.ctrl});
        check({tag, ".alu"},  ALUOut, got.alu);
        check({tag, ".zero"}, {31'd0, Zero}, {31'd0, got.zero});
        check({tag, ".rd"},   MemReadData, got.rd);
        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < 128; i++) mdl_mem[i] = 32'd0;
        end else if (op == 6'b101011) begin
            mdl_mem[addr] = wd;
        end
        #1;
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [3:0] codes [8];
        ops   = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b111111};
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011, 4'b1111};
        for (int i = 0; i < 128; i++) mdl_mem[i] = 32'hxxxxxxxx;
        reset = 1'b1; Opcode = 6'd0; ALUCtrl = 4'd0; A = 32'd0; B = 32'd0;
        MemAddress = 7'd0; MemWriteData = 32'd0;
        @(posedge clock); #1;

        step(1'b1, 6'b101011, 4'b0010, 32'd3, 32'd4, 7'd9, 32'hAAAA5555, "rst_hold");
        step(1'b0, 6'b100011, 4'b0000, 32'd0, 32'd0, 7'd9, 32'd0, "post_rst_rd");
        step(1'b0, 6'b000000, 4'b0110, 32'd20, 32'd15, 7'd0, 32'd0, "sub");
        step(1'b0, 6'b000000, 4'b0110, 32'd15, 32'd15, 7'd0, 32'd0, "sub_zero");
        step(1'b0, 6'b000000, 4'b0001, 32'd20, 32'd15, 7'd0, 32'd0, "or");
        step(1'b0, 6'b000000, 4'b0010, 32'd20, 32'd15, 7'd0, 32'd0, "add");
        step(1'b0, 6'b000000, 4'b0000, 32'd20, 32'd15, 7'd0, 32'd0, "and");
        step(1'b0, 6'b000000, 4'b0111, 32'hFFFFFFFF, 32'd1, 7'd0, 32'd0, "slt_neg");
        step(1'b0, 6'b000000, 4'b0111, 32'd1, 32'hFFFFFFFF, 7'd0, 32'd0, "slt_swap");
        step(1'b0, 6'b000000, 4'b1100, 32'd0, 32'd0, 7'd0, 32'd0, "nor");
        step(1'b0, 6'b000000, 4'b0011, 32'd7, 32'd9, 7'd0, 32'd0, "bad_code");
        step(1'b0, 6'b000000, 4'b0010, 32'hFFFFFFFF, 32'd1, 7'd0, 32'd0, "add_wrap");
        step(1'b0, 6'b000100, 4'b0110, 32'd5, 32'd5, 7'd0, 32'd0, "beq");
        step(1'b0, 6'b001000, 4'b0010, 32'd1, 32'd2, 7'd0, 32'd0, "addi");
        step(1'b0, 6'b111111, 4'b0010, 32'd1, 32'd2, 7'd0, 32'd0, "op_ff");
        step(1'b0, 6'b101011, 4'b0010, 32'd0, 32'd5, 7'd5, 32'hDEADBEEF, "sw5");
        step(1'b0, 6'b100011, 4'b0010, 32'd0, 32'd5, 7'd5, 32'd0, "lw5");
        step(1'b0, 6'b000000, 4'b0010, 32'd0, 32'd5, 7'd5, 32'd0, "rtype_rd5");
        step(1'b0, 6'b101011, 4'b0010, 32'd0, 32'd6, 7'd6, 32'h0BADF00D, "sw6");
        step(1'b0, 6'b101011, 4'b0010, 32'd0, 32'd6, 7'd6, 32'h11112222, "sw6_over");
        step(1'b0, 6'b100011, 4'b0010, 32'd0, 32'd6, 7'd6, 32'd0, "lw6");
        step(1'b0, 6'b100011, 4'b0010, 32'd0, 32'd5, 7'd127, 32'd0, "lw127");
        step(1'b1, 6'b101011, 4'b0010, 32'd0, 32'd5, 7'd5, 32'h12345678, "rst_sw");
        step(1'b0, 6'b100011, 4'b0010, 32'd0, 32'd5, 7'd5, 32'd0, "lw5_after_rst");
        step(1'b0, 6'b100011, 4'b0010, 32'd0, 32'd6, 7'd6, 32'd0, "lw6_after_rst");

        for (int n = 0; n < 60; n++) begin
            step(1'b0, ops[$urandom_range(0, 5)], codes[$urandom_range(0, 7)],
                 $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                 7'($urandom_range(0, 7)), $urandom, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
